// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcodes, memory-map constants, fetch FSM state and buffer payload.
package instr_fetch_unit_pkg;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] TEXT_ADDRESS = 32'h0040_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction fetches are word granular; the low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Reservation FIFO: a slot is reserved with its PC at request accept and filled in order by responses.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       reserve,
  input  logic [31:0]                reserve_pc,
  input  logic                       fill,
  input  logic [31:0]                fill_instr,
  input  logic                       pop,
  output logic                       head_valid,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    fill_ptr_q;
  logic [CW-1:0]    count_q;

  // Control state; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      filled_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      if (pop) begin
        filled_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      if (reserve) begin
        filled_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (fill) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= fill_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(reserve) - CW'(pop);
    end
  end

  // Payload storage needs no reset; the filled flags qualify it.
  always_ff @(posedge clk) begin
    if (reserve) begin
      mem_q[wr_ptr_q].pc <= reserve_pc;
    end
    if (fill) begin
      mem_q[fill_ptr_q].instr <= fill_instr;
    end
  end

  assign head_valid = filled_q[rd_ptr_q];
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-order memory requests with variable-latency responses, redirect flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = TEXT_ADDRESS,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemReady,
  input  logic        iMemRValid,
  input  logic [31:0] iMemRData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oValid,
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  input  logic        iReady
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          mem_req_c;
  logic          accept_c;
  logic          rsp_c;
  logic [CW-1:0] inflight_c;
  logic          buf_clear;
  logic          buf_reserve;
  logic          buf_fill;
  logic          buf_pop;
  logic          head_valid;
  fetch_entry_t  head;
  logic [CW-1:0] buf_count;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Next state, counters and buffer controls; redirect overrides everything else in its cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    mem_req_c     = 1'b0;
    accept_c      = 1'b0;
    buf_clear     = 1'b0;
    buf_reserve   = 1'b0;
    buf_fill      = 1'b0;
    buf_pop       = 1'b0;

    inflight_c = (state_q == FLUSH) ? discard_q : outstanding_q;
    rsp_c      = iMemRValid && (inflight_c != '0);

    if (iRedirect) begin
      buf_clear     = 1'b1;
      pc_d          = word_align(iRedirectPC);
      outstanding_d = '0;
      discard_d     = inflight_c - CW'(rsp_c);
      state_d       = (discard_d != '0) ? FLUSH : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          buf_pop     = head_valid && iReady;
          mem_req_c   = (buf_count < CW'(DEPTH)) || buf_pop;
          accept_c    = mem_req_c && iMemReady;
          buf_reserve = accept_c;
          buf_fill    = rsp_c;
          if (accept_c) begin
            pc_d = pc_q + 32'd4;
          end
          outstanding_d = outstanding_q + CW'(accept_c) - CW'(rsp_c);
        end
        FLUSH: begin
          if (rsp_c) begin
            discard_d = discard_q - CW'(1);
          end
          if (discard_d == '0) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_fetch_buffer (
    .clk        (iCLK),
    .rst        (iRST),
    .clear      (buf_clear),
    .reserve    (buf_reserve),
    .reserve_pc (pc_q),
    .fill       (buf_fill),
    .fill_instr (iMemRData),
    .pop        (buf_pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (buf_count)
  );

  // Outputs are quiet while reset is held.
  assign oMemReq  = mem_req_c && !iRST;
  assign oMemAddr = pc_q;
  assign oValid   = head_valid && !iRST;
  assign oInstr   = oValid ? head.instr : ZERO;
  assign oPC      = oValid ? head.pc : ZERO;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;

  logic        iCLK;
  logic        iRST;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemReady;
  logic        iMemRValid;
  logic [31:0] iMemRData;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oValid;
  logic [31:0] oInstr;
  logic [31:0] oPC;
  logic        iReady;

  instr_fetch_unit #(
    .RESET_PC(32'h0040_0000),
    .DEPTH   (2)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .oMemReq    (oMemReq),
    .oMemAddr   (oMemAddr),
    .iMemReady  (iMemReady),
    .iMemRValid (iMemRValid),
    .iMemRData  (iMemRData),
    .iRedirect  (iRedirect),
    .iRedirectPC(iRedirectPC),
    .oValid     (oValid),
    .oInstr     (oInstr),
    .oPC        (oPC),
    .iReady     (iReady)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] acc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: drive memory response, log accepts/pops, advance to 1 time unit after the edge.
  task automatic cycle();
    req_t r;
    if (iRST) mq.delete();
    if (!iRST && mq.size() > 0 && mq[0].due <= cyc) begin
      iMemRValid = 1'b1;
      iMemRData  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      iMemRValid = 1'b0;
      iMemRData  = 32'h0;
    end
    #1;
    if (oMemReq && iMemReady) begin
      r.addr = oMemAddr;
      r.due  = cyc + lat;
      mq.push_back(r);
      acc.push_back(oMemAddr);
    end
    if (oValid && iReady) begin
      pop_pc.push_back(oPC);
      pop_ins.push_back(oInstr);
    end
    @(posedge iCLK);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    iRST        = 1'b1;
    iRedirect   = 1'b0;
    iRedirectPC = 32'h0;
    iReady      = 1'b0;
    iMemReady   = 1'b0;
    iMemRValid  = 1'b0;
    iMemRData   = 32'h0;
    cycle();
    cycle();
    iRST = 1'b0;
    mq.delete();
    acc.delete();
    pop_pc.delete();
    pop_ins.delete();
    settle();
  endtask

  task automatic chk_pop(input string tag, input int idx, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_avail"}, 32'(pop_pc.size() > idx), 32'd1);
    if (pop_pc.size() > idx) begin
      chk({tag, "_pc"}, pop_pc[idx], pc);
      chk({tag, "_instr"}, pop_ins[idx], ins);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    lat      = 1;

    // Reset values while reset is held
    iRST        = 1'b1;
    iRedirect   = 1'b0;
    iRedirectPC = 32'h0;
    iReady      = 1'b1;
    iMemReady   = 1'b1;
    iMemRValid  = 1'b0;
    iMemRData   = 32'h0;
    cycle();
    chk("rst_req", 32'(oMemReq), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_instr", oInstr, 32'h0);
    chk("rst_pc", oPC, 32'h0);

    // Test 1: streaming with 1-cycle memory
    do_reset();
    lat = 1; iMemReady = 1'b1; iReady = 1'b1;
    settle();
    chk("t1_req0", 32'(oMemReq), 32'd1);
    chk("t1_addr0", oMemAddr, 32'h0040_0000);
    cycle();
    chk("t1_valid_early", 32'(oValid), 32'd0);
    chk("t1_addr1", oMemAddr, 32'h0040_0004);
    cycle();
    chk("t1_valid", 32'(oValid), 32'd1);
    chk("t1_pc", oPC, 32'h0040_0000);
    chk("t1_instr", oInstr, 32'hA5E5_0000);
    chk("t1_addr2", oMemAddr, 32'h0040_0008);
    chk("t1_req_full_pop", 32'(oMemReq), 32'd1);
    run(6);
    for (int i = 0; i < 5; i++)
      chk_pop("t1_pop", i, 32'h0040_0000 + 32'(4 * i), mem_word(32'h0040_0000 + 32'(4 * i)));

    // Test 2: decode stalls, buffer fills, then drains
    do_reset();
    lat = 1; iMemReady = 1'b1; iReady = 1'b0;
    run(5);
    chk("t2_accepts", 32'(acc.size()), 32'd2);
    chk("t2_req_stall", 32'(oMemReq), 32'd0);
    chk("t2_valid", 32'(oValid), 32'd1);
    chk("t2_pc_hold", oPC, 32'h0040_0000);
    chk("t2_instr_hold", oInstr, 32'hA5E5_0000);
    iReady = 1'b1;
    settle();
    chk("t2_req_resume", 32'(oMemReq), 32'd1);
    chk("t2_addr_resume", oMemAddr, 32'h0040_0008);
    cycle();
    chk("t2_pc_next", oPC, 32'h0040_0004);
    cycle();
    chk("t2_pc_next2", oPC, 32'h0040_0008);

    // Test 3: redirect with two requests in flight, latency 3
    do_reset();
    lat = 3; iMemReady = 1'b1; iReady = 1'b1;
    run(3);
    chk("t3_full_noreq", 32'(oMemReq), 32'd0);
    iRedirect = 1'b1; iRedirectPC = 32'h0040_0100;
    settle();
    chk("t3_redir_noreq", 32'(oMemReq), 32'd0);
    cycle();
    iRedirect = 1'b0;
    settle();
    chk("t3_flush_noreq", 32'(oMemReq), 32'd0);
    chk("t3_flush_valid", 32'(oValid), 32'd0);
    cycle();
    chk("t3_resume_req", 32'(oMemReq), 32'd1);
    chk("t3_resume_addr", oMemAddr, 32'h0040_0100);
    run(8);
    chk_pop("t3_first", 0, 32'h0040_0100, 32'hA5E5_0100);
    chk("t3_naccept_avail", 32'(acc.size() > 2), 32'd1);
    if (acc.size() > 2) chk("t3_acc2", acc[2], 32'h0040_0100);

    // Test 4: irregular ready patterns; PC order must stay strictly +4
    do_reset();
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      iReady    = (i % 3) != 1;
      iMemReady = (i % 4) != 2;
      cycle();
    end
    iReady = 1'b1; iMemReady = 1'b0;
    run(6);
    chk("t4_npops", 32'(pop_pc.size() >= 8), 32'd1);
    exp_pc = 32'h0040_0000;
    for (int i = 0; i < pop_pc.size(); i++) begin
      chk("t4_pc_seq", pop_pc[i], exp_pc);
      chk("t4_instr_seq", pop_ins[i], mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end

    // Test 5: misaligned redirect target is forced to a word boundary
    do_reset();
    lat = 1; iMemReady = 1'b1; iReady = 1'b1;
    iRedirect = 1'b1; iRedirectPC = 32'h0040_0006;
    cycle();
    iRedirect = 1'b0;
    settle();
    chk("t5_addr", oMemAddr, 32'h0040_0004);
    chk("t5_req", 32'(oMemReq), 32'd1);
    run(4);
    chk_pop("t5_first", 0, 32'h0040_0004, 32'hA5E5_0004);

    // Test 6: reset while flushing
    do_reset();
    lat = 3; iMemReady = 1'b1; iReady = 1'b1;
    run(3);
    iRedirect = 1'b1; iRedirectPC = 32'h0040_0200;
    cycle();
    iRedirect = 1'b0; iRST = 1'b1;
    settle();
    chk("t6_rst_req", 32'(oMemReq), 32'd0);
    cycle();
    chk("t6_rst_req_after", 32'(oMemReq), 32'd0);
    chk("t6_rst_valid_after", 32'(oValid), 32'd0);
    chk("t6_rst_pc_after", oPC, 32'h0);
    iRST = 1'b0;
    settle();
    chk("t6_req", 32'(oMemReq), 32'd1);
    chk("t6_addr", oMemAddr, 32'h0040_0000);
    pop_pc.delete();
    pop_ins.delete();
    run(8);
    chk_pop("t6_first", 0, 32'h0040_0000, 32'hA5E5_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the decode stage that holds the immediate generator and control decoder. Keeps the PC and issues in-order word requests to instruction memory using a ready/valid request and variable-latency response protocol. Buffers up to DEPTH instructions and presents each one with its PC to decode over a valid/ready handshake. Supports redirect (branch/jump/trap target), which flushes both buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset; equals the text-segment base constant.
DEPTH, 2, buffer entries; also the cap on outstanding plus buffered requests (power of 2, ≥2).

Ports:
iCLK  in  1  clock; all state updates on rising edge.
iRST  in  1  reset, synchronous, active-high.
oMemReq  out  1  fetch request valid.
oMemAddr  out  32  word address of the request; bits [1:0] always 00.
iMemReady  in  1  memory accepts the request this cycle.
iMemRValid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
iMemRData  in  32  instruction word.
iRedirect  in  1  discard the stream and refetch from iRedirectPC.
iRedirectPC  in  32  new PC; bits [1:0] ignored (forced 00).
oValid  out  1  buffer head holds an instruction.
oInstr  out  32  head instruction, feeds decode / immediate generation.
oPC  out  32  PC of the head instruction.
iReady  in  1  decode consumes the head when oValid&iReady.

Behaviour:
- Reset (iRST=1 at edge): PC=RESET_PC, buffer empty, outstanding=0, discard=0, state=FETCH. While iRST=1: oMemReq=0, oValid=0, oInstr=0, oPC=0.
- Memory shares iRST. No responses are expected after reset; a response arriving with outstanding=0 is ignored (bench asserts).
- States: FETCH, FLUSH.
- FETCH issue: oMemReq=1 iff state=FETCH, !iRedirect, and (outstanding + buffered) < DEPTH. oMemAddr=PC.
- FETCH accept: on oMemReq&iMemReady, PC+=4 (mod 2^32), a buffer slot is reserved with its PC, and outstanding+1.
- Response in FETCH: fills the oldest reserved-but-empty slot with iMemRData; outstanding-1.
- Head and latency: oValid=1 when the head slot is filled. Minimum latency from request acceptance to oValid is 2 cycles (1-cycle memory plus registered buffer).
- Pop: oValid&iReady frees the head. Same-cycle pop, fill and reserve are all legal. A full buffer with a pop may reserve again in the same cycle.
- Redirect has priority over all other events in its cycle:
  - buffer cleared (oValid=0 next cycle);
  - PC = {iRedirectPC[31:2],2'b00};
  - oMemReq forced 0;
  - discard = outstanding − (iMemRValid ? 1 : 0).
  - Next state is FLUSH if discard>0, else FETCH.
- FLUSH:
  - no requests issued;
  - each iMemRValid decrements discard, and its data is dropped;
  - when discard reaches 0 (including on the final response edge), go to FETCH; issue resumes the following cycle.
- Redirect during FLUSH: only the PC is updated; discard is recomputed by the same rule.
- Counters are sized $clog2(DEPTH)+1 bits and never overflow, because issue is capped at DEPTH.
- oInstr and oPC hold stable while oValid=1 and iReady=0.

Decomposition:
- Shared package (alongside the existing opcode/ZERO parameters):
  - TEXT_ADDRESS constant used as the RESET_PC default;
  - fetch_state_t enum {FETCH, FLUSH};
  - NOP instruction constant 32'h0000_0013 for bench bubbles.
- One sub-module, fetch_buffer: a reservation FIFO of DEPTH entries {pc, instr, filled} with reserve/fill/pop/clear ports, and pointers that wrap modulo DEPTH.
- The top level holds the PC register, outstanding/discard counters and the FSM.

Test Plan:
1. Reset, then 1-cycle memory with iReady=1 → oMemAddr sequence 0x00400000, 0x00400004, 0x00400008. First oValid arrives 2 cycles after the first accept, with oPC=0x00400000 and oInstr equal to the memory word.
2. iReady=0, 1-cycle memory → after 2 accepts oMemReq stays 0 and oValid holds 0x00400000/instr0 unchanged. Raising iReady → one pop per cycle and issue resumes.
3. Memory latency 3 with 2 requests outstanding, then iRedirect with iRedirectPC=0x00400100 → both responses dropped and no oValid for them. Next oMemAddr=0x00400100 only after the second stale response. First oPC is 0x00400100.
4. Full buffer, pop and response in the same cycle with iMemReady=1 → new slot reserved the same cycle and no ordering violation. oPC sequence stays strictly +4.
5. iRedirectPC=0x00400006 → next fetch address and oPC are 0x00400004.
6. iRST asserted in FLUSH with discard=1 → next cycle oMemReq=0, oValid=0. After release, first oMemAddr is 0x00400000.
